// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply datapath: default operand widths,
// a constant-foldable clog2 and the accumulator FSM state type.
package matmul_pkg;

    localparam int W_A = 8;
    localparam int W_B = 8;
    localparam int W_P = W_A + W_B;

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dot_product_accumulator_result_slot.sv
// Single-entry output register holding one dot-product result; owns out_valid
// and the upstream in_ready decision.
module result_slot #(
    parameter int W_acc = 24,
    parameter int W_len = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W_acc-1:0] sum_d,
    input  logic [W_len-1:0] len_d,
    input  logic             len_err_d,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             in_ready,
    output logic [W_acc-1:0] sum,
    output logic [W_len-1:0] len,
    output logic             len_err
);

    // Depends only on registered state and reset, never on the incoming beat.
    assign in_ready = ~rst & (~out_valid | out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            len       <= '0;
            len_err   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            sum       <= sum_d;
            len       <= len_d;
            len_err   <= len_err_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dot_product_accumulator.sv
// Streaming unsigned dot-product accumulator: sums products until in_last or
// MAX_LEN terms, then hands one result downstream through a one-deep slot.
//
// Handshake: a beat moves when in_valid & in_ready on a rising edge, a result
// moves when out_valid & out_ready; valid never waits on ready.
module dot_product_accumulator
    import matmul_pkg::*;
#(
    parameter int W_p     = W_P,
    parameter int MAX_LEN = 256,
    parameter int W_acc   = 24,
    parameter int W_len   = 9
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_p-1:0]   product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_acc-1:0] sum,
    output logic [W_len-1:0] len,
    output logic             len_err,
    output acc_state_t       state
);

    if (MAX_LEN < 1 || W_acc < W_p + clog2(MAX_LEN) || W_len < clog2(MAX_LEN + 1)) begin : g_bad_params
        $error("dot_product_accumulator: W_acc/W_len too narrow for MAX_LEN");
    end

    logic [W_acc-1:0] acc;
    logic [W_len-1:0] cnt;
    logic             accept;
    logic             closing;
    logic [W_acc-1:0] acc_next;
    logic [W_len-1:0] cnt_next;

    assign accept   = in_valid & in_ready;
    assign closing  = accept & (in_last | (cnt == W_len'(MAX_LEN - 1)));
    // Width rule guarantees no carry out, so a plain add is exact.
    assign acc_next = acc + W_acc'(product);
    assign cnt_next = cnt + W_len'(1);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc   <= '0;
            cnt   <= '0;
            state <= EMPTY;
        end else if (closing) begin
            acc   <= '0;
            cnt   <= '0;
            state <= EMPTY;
        end else if (accept) begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            state <= ACCUM;
        end
    end

    result_slot #(
        .W_acc (W_acc),
        .W_len (W_len)
    ) u_slot (
        .clk       (Clock),
        .rst       (Reset),
        .load      (closing),
        .sum_d     (acc_next),
        .len_d     (cnt_next),
        .len_err_d (~in_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .len       (len),
        .len_err   (len_err)
    );

endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Streaming accumulator that sits directly downstream of `noOverflowMult`. It sums a sequence of unsigned products into one dot-product result per vector, with vectors delimited by a last flag. The accumulator is sized so it cannot overflow for the configured maximum vector length. Results leave through a valid/ready handshake toward the matrix-multiply result writer.

## Interface
- `W_p`, default 16: width of the incoming unsigned product; equals `W_a + W_b` of the multiplier.
- `MAX_LEN`, default 256: maximum number of terms per vector; must be ≥ 1.
- `W_acc`, default 24: accumulator and result width; must be ≥ `W_p + clog2(MAX_LEN)`. Elaboration fails otherwise.
- `W_len`, default 9: length field width, `clog2(MAX_LEN+1)`.

Ports (clock and reset first):
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a product beat is present.
- `in_ready`  out  1  the block accepts the beat this cycle.
- `product`  in  `W_p`  unsigned product from the multiplier.
- `in_last`  in  1  this beat is the final term of the vector.
- `out_valid`  out  1  a result is held.
- `out_ready`  in  1  the consumer takes the result this cycle.
- `sum`  out  `W_acc`  dot-product result.
- `len`  out  `W_len`  number of terms summed.
- `len_err`  out  1  vector was force-closed at `MAX_LEN` without `in_last`.

## Operation
- Beat accepted ⇔ `in_valid & in_ready`.
- Transfer out ⇔ `out_valid & out_ready`.
- `in_ready = ~Reset & (~out_valid | out_ready)`. This is registered-state based and does not depend on `in_valid` or `in_last`.
- Internal state: accumulator `acc[W_acc-1:0]` and term counter `cnt[W_len-1:0]`.
- FSM states:
  - EMPTY (`cnt == 0`).
  - ACCUM (`0 < cnt < MAX_LEN`).
  - The output slot (`out_valid`) is tracked independently of the FSM.
- On an accepted non-closing beat:
  - `acc <= acc + product` (zero-extended).
  - `cnt <= cnt + 1`.
  - EMPTY → ACCUM.
- Closing beat: an accepted beat with `in_last`, or one with `cnt == MAX_LEN-1`.
  - `sum <= acc + product`, `len <= cnt + 1`, `len_err <= ~in_last`, `out_valid <= 1`.
  - `acc <= 0`, `cnt <= 0`; next state EMPTY.
- Single-term vector (`in_last` on the first beat): `sum = product`, `len = 1`.
- Transfer out with no simultaneous closing beat: `out_valid <= 0`. `sum`, `len` and `len_err` keep their last values.
- Transfer out together with a closing beat: the new result loads and `out_valid` stays 1.
- A beat that arrives after a force-close starts a new vector.
- Arithmetic is unsigned only. The width rule guarantees there is no carry out of `W_acc`, so no saturation or wrap logic is needed.
- Reset (asynchronous, any time, including mid-vector or with a result pending):
  - `acc = 0`, `cnt = 0`, state EMPTY.
  - `out_valid = 0`, `sum = 0`, `len = 0`, `len_err = 0`.
  - `in_ready = 0` while `Reset` is high.
  - The partial vector is discarded.

## Timing
- Latency: a result is valid on the cycle after the closing beat's rising edge.
- Throughput: one beat per cycle, with no bubbles between vectors while `out_ready` is held high.
- Backpressure: while `out_valid & ~out_ready`, `in_ready = 0`. `sum`, `len` and `len_err` hold stable until the transfer.
- `product` and `in_last` are sampled only on accepted beats and are ignored otherwise.
- First acceptance is possible on the first rising edge after `Reset` deasserts.

## Structure
- Shared package `matmul_pkg` holds:
  - `clog2` function.
  - Default widths `W_A = 8`, `W_B = 8`, `W_P = W_A + W_B`.
  - The FSM state typedef (EMPTY, ACCUM).
- One natural sub-module: `result_slot`, a single-entry output register that provides `out_valid` and the `in_ready` computation.

## Test plan
Configuration for all scenarios: `W_p = 16`, `MAX_LEN = 4`, `W_acc = 18`, `W_len = 3`.
1. Beats 65025×4 with `in_last` on the 4th, `out_ready = 1` → one cycle later `sum = 260100`, `len = 4`, `len_err = 0`.
2. Back-to-back single-term vectors 1, 2, 3, each with `in_last`, and `out_ready = 1` → `sum` = 1, 2, 3 on consecutive cycles; `in_ready` stays 1.
3. Vector {4, 6} last, then `out_ready = 0` for 5 cycles → `sum = 10`, `len = 2` held; `in_ready = 0`; when `out_ready` rises, the next vector's beat is accepted that same cycle.
4. Five beats of value 1 with no `in_last` → first result `sum = 4`, `len = 4`, `len_err = 1`; the 5th beat begins a new vector.
5. Beats 3, 5, then assert `Reset` mid-vector → all outputs 0 immediately. After release, beat 7 with last → `sum = 7`, `len = 1`.
6. Vector {0, 0, 9} last, with `in_valid` gaps between beats → `sum = 9`, `len = 3`; products present on non-valid cycles are ignored.
